win_detector: RTL

- Scans a latched 3x3 tic-tac-toe board one line per cycle and produces the 2-bit `detect_win` result code.
- It is the producer of the `detect_win` code that the RGB LED driver consumes.
- Result codes:
  - 01 = player 1 wins
  - 10 = player 2 wins
  - 11 = draw (board full, no winner)
  - 00 = game in progress
- Sits between the board-state register and the LED driver; the game controller triggers it after each move.

---
 rtl/win_detector_pkg.sv | 41 ++++
 rtl/win_detector_if.sv | 36 +++
 rtl/win_detector_line_eval.sv | 31 +++
 rtl/win_detector.sv | 139 +++++++++++++
 4 files changed

// File: rtl/win_detector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : win_detector_pkg
//  Description : Shared constants for the tic-tac-toe win detector: result
//                codes, cell encodings, FSM state encoding and the table
//                mapping each of the eight scan lines to its three cells.
//  Revision    : 1.0  initial release
// ============================================================================
package win_detector_pkg;

  // Result codes driven on detect_win
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  // Cell encodings (any value other than P1/P2 counts as empty)
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Line-to-cell table, listed from line 7 down to line 0 so that
  // LINE_TBL[k] is scan line k. Cell order inside a line does not matter.
  localparam logic [7:0][2:0][3:0] LINE_TBL = '{
    '{4'd6, 4'd4, 4'd2},  // 7: anti-diagonal
    '{4'd8, 4'd4, 4'd0},  // 6: main diagonal
    '{4'd8, 4'd5, 4'd2},  // 5: column 2
    '{4'd7, 4'd4, 4'd1},  // 4: column 1
    '{4'd6, 4'd3, 4'd0},  // 3: column 0
    '{4'd8, 4'd7, 4'd6},  // 2: row 2
    '{4'd5, 4'd4, 4'd3},  // 1: row 1
    '{4'd2, 4'd1, 4'd0}   // 0: row 0
  };

endpackage : win_detector_pkg
`default_nettype wire

// File: rtl/win_detector_if.sv
`default_nettype none
// ============================================================================
//  Module      : win_detector_if
//  Description : Request/result bundle between the game controller and the
//                win detector. With WIN_LINE_OUT_EN defined the bundle also
//                carries the winning line index and its valid flag.
//  Revision    : 1.0  initial release
// ============================================================================
interface win_detector_if;

  logic        start;
  logic [17:0] board;
  logic        busy;
  logic        done;
  logic [1:0]  detect_win;
`ifdef WIN_LINE_OUT_EN
  logic [2:0]  win_line;
  logic        win_line_vld;
`endif

`ifdef WIN_LINE_OUT_EN
  modport master (output start, output board,
                  input busy, input done, input detect_win,
                  input win_line, input win_line_vld);
  modport slave  (input start, input board,
                  output busy, output done, output detect_win,
                  output win_line, output win_line_vld);
`else
  modport master (output start, output board,
                  input busy, input done, input detect_win);
  modport slave  (input start, input board,
                  output busy, output done, output detect_win);
`endif

endinterface : win_detector_if
`default_nettype wire

// File: rtl/win_detector_line_eval.sv
`default_nettype none
// ============================================================================
//  Module      : line_eval
//  Description : Combinational judge for one board line: reports which
//                player (if any) owns all three cells.
//  Revision    : 1.0  initial release
// ============================================================================
module line_eval
  import win_detector_pkg::*;
#(
  parameter logic [1:0] P1_CODE = CELL_P1,
  parameter logic [1:0] P2_CODE = CELL_P2
) (
  input  wire logic [1:0] cell_a,
  input  wire logic [1:0] cell_b,
  input  wire logic [1:0] cell_c,
  output logic      [1:0] result
);

  // A line is won only when all three cells carry the same player mark
  always_comb begin
    result = RES_NONE;
    if (cell_a == P1_CODE && cell_b == P1_CODE && cell_c == P1_CODE) begin
      result = RES_P1;
    end else if (cell_a == P2_CODE && cell_b == P2_CODE && cell_c == P2_CODE) begin
      result = RES_P2;
    end
  end

endmodule : line_eval
`default_nettype wire

// File: rtl/win_detector.sv
`default_nettype none
// ============================================================================
//  Module      : win_detector
//  Description : Latches a 3x3 board on start and evaluates one line per
//                cycle, exiting early on the first win. After the last line
//                with no winner it reports draw (board full) or in-progress.
//                Optional macro WIN_LINE_OUT_EN adds win_line/win_line_vld.
//  Revision    : 1.0  initial release
// ============================================================================
module win_detector
  import win_detector_pkg::*;
#(
  parameter logic [1:0] P1_CODE = CELL_P1,
  parameter logic [1:0] P2_CODE = CELL_P2
) (
  input  wire logic   clk,
  input  wire logic   rst,
  win_detector_if.slave bus
);

  logic [1:0]  state_q, state_d;
  logic [2:0]  line_idx_q, line_idx_d;
  logic [17:0] board_q, board_d;
  logic [1:0]  detect_win_q, detect_win_d;
`ifdef WIN_LINE_OUT_EN
  logic [2:0]  win_line_q, win_line_d;
  logic        win_line_vld_q, win_line_vld_d;
`endif

  logic [1:0]  cells [9];
  logic [1:0]  line_cells [3];
  logic [1:0]  line_res;
  logic        board_full;

  // Split the latched board into individual cells
  for (genvar i = 0; i < 9; i++) begin : g_cell
    assign cells[i] = board_q[2*i +: 2];
  end

  // Pick the three cells of the line currently under evaluation
  for (genvar j = 0; j < 3; j++) begin : g_line_cell
    assign line_cells[j] = cells[LINE_TBL[line_idx_q][j]];
  end

  line_eval #(
    .P1_CODE (P1_CODE),
    .P2_CODE (P2_CODE)
  ) u_line_eval (
    .cell_a (line_cells[0]),
    .cell_b (line_cells[1]),
    .cell_c (line_cells[2]),
    .result (line_res)
  );

  // Board is full only when every cell holds a real player mark
  always_comb begin
    board_full = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (cells[k] != P1_CODE && cells[k] != P2_CODE) begin
        board_full = 1'b0;
      end
    end
  end

  // Next-state logic: latch on start, walk the lines, settle the result
  always_comb begin
    state_d      = state_q;
    line_idx_d   = line_idx_q;
    board_d      = board_q;
    detect_win_d = detect_win_q;
`ifdef WIN_LINE_OUT_EN
    win_line_d     = win_line_q;
    win_line_vld_d = win_line_vld_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          board_d    = bus.board;
          line_idx_d = 3'd0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (line_res != RES_NONE) begin
          detect_win_d = line_res;
          state_d      = ST_DONE;
`ifdef WIN_LINE_OUT_EN
          win_line_d     = line_idx_q;
          win_line_vld_d = 1'b1;
`endif
        end else if (line_idx_q == 3'd7) begin
          detect_win_d = board_full ? RES_DRAW : RES_NONE;
          state_d      = ST_DONE;
`ifdef WIN_LINE_OUT_EN
          win_line_d     = 3'd0;
          win_line_vld_d = 1'b0;
`endif
        end else begin
          line_idx_d = line_idx_q + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      line_idx_q   <= 3'd0;
      board_q      <= 18'd0;
      detect_win_q <= RES_NONE;
`ifdef WIN_LINE_OUT_EN
      win_line_q     <= 3'd0;
      win_line_vld_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      line_idx_q   <= line_idx_d;
      board_q      <= board_d;
      detect_win_q <= detect_win_d;
`ifdef WIN_LINE_OUT_EN
      win_line_q     <= win_line_d;
      win_line_vld_q <= win_line_vld_d;
`endif
    end
  end

  assign bus.busy       = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.detect_win = detect_win_q;
`ifdef WIN_LINE_OUT_EN
  assign bus.win_line     = win_line_q;
  assign bus.win_line_vld = win_line_vld_q;
`endif

endmodule : win_detector
`default_nettype wire
